// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register file slave: response codes, FSM states
// and the byte-offset width of a data word.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_regfile_mem.sv
// NUM_REGS x DATA_WIDTH storage: one byte-enabled write port, one registered read port,
// both cleared synchronously by rst.
module axil_regfile_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [IDX_W-1:0]        ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the pre-write contents when both ports hit the same word on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) begin
            mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
      if (re_i) begin
        rdata_q <= mem_q[ridx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave over a register file; independent AW/W slots, SLVERR on out-of-range.
// Build option AXIL_REGFILE_ALIGN_CHECK_EN: misaligned addresses also answer SLVERR.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = addr_lsb(DATA_WIDTH);
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                  aw_err, ar_err;

  assign aw_word = AWADDR >> LSB;
  assign ar_word = ARADDR >> LSB;
`ifdef AXIL_REGFILE_ALIGN_CHECK_EN
  assign aw_err = (aw_word >= ADDR_WIDTH'(NUM_REGS)) || (AWADDR[LSB-1:0] != '0);
  assign ar_err = (ar_word >= ADDR_WIDTH'(NUM_REGS)) || (ARADDR[LSB-1:0] != '0);
`else
  assign aw_err = (aw_word >= ADDR_WIDTH'(NUM_REGS));
  assign ar_err = (ar_word >= ADDR_WIDTH'(NUM_REGS));
`endif

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_full_q, aw_full_d, aw_err_q, aw_err_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic                  mem_we;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    aw_err_d   = aw_err_q;
    w_full_d   = w_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        // Commit lands one edge after the later of the two slots fills.
        if (aw_full_q && w_full_q) begin
          mem_we     = !aw_err_q;
          bvalid_d   = 1'b1;
          bresp_d    = aw_err_q ? SLVERR : OKAY;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          wr_state_d = W_RESP;
        end else begin
          if (AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = aw_word[IDX_W-1:0];
            aw_err_d  = aw_err;
          end
          if (WVALID && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = WDATA;
            wstrb_d  = WSTRB;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          bresp_d    = OKAY;
          wr_state_d = W_IDLE;
        end
      end
    endcase
    awready_d = (wr_state_d == W_IDLE) && !aw_full_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      aw_err_q   <= aw_err_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  rd_state_t rd_state_q, rd_state_d;
  logic      arready_q, arready_d, rvalid_q, rvalid_d, mem_re;
  resp_t     rresp_q, rresp_d;

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    mem_re     = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          mem_re     = 1'b1;
          rvalid_d   = 1'b1;
          rresp_d    = ar_err ? SLVERR : OKAY;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rresp_d    = OKAY;
          rd_state_d = R_IDLE;
        end
      end
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem_rdata;

  axil_regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .widx_i  (aw_idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (mem_re),
    .ridx_i  (ar_word[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = (rresp_q == SLVERR) ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Randomised bench for axi_lite_regfile_slave against a transaction-level model,
// preceded by directed cases with hand-computed expectations.
module tb_axi_lite_regfile_slave;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NR  = 256;
  localparam int SW  = DW / 8;
  localparam int LSB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [SW-1:0] WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b1;

  axi_lite_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [NR];
  bit            m_rdy_ok, m_aw_got, m_w_got, m_commit, m_bvalid, m_rvalid;
  logic [1:0]    m_bresp, m_rresp;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [AW-1:0] m_awaddr;
  logic [SW-1:0] m_wstrb;
  bit            rst_edge = 1'b1;
  bit            e_awr, e_wr, e_arr;

  function automatic bit m_err(input logic [AW-1:0] a);
    bit e;
    e = (a >> LSB) >= AW'(NR);
`ifdef AXIL_REGFILE_ALIGN_CHECK_EN
    if (a[LSB-1:0] != '0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_rdy_ok = 0; m_aw_got = 0; m_w_got = 0; m_commit = 0;
    m_bvalid = 0; m_rvalid = 0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
  endfunction

  // Advance the model across the coming clock edge; reads see the array before
  // any write that commits on the same edge.
  function automatic void model_step(input bit awr, input bit wr, input bit arr);
    int idx;
    if (ARVALID && arr) begin
      m_rvalid = 1;
      if (m_err(ARADDR)) begin m_rresp = 2'b10; m_rdata = '0; end
      else begin m_rresp = 2'b00; m_rdata = m_mem[int'(ARADDR >> LSB)]; end
    end else if (m_rvalid && RREADY) begin
      m_rvalid = 0;
    end
    if (m_bvalid && BREADY) m_bvalid = 0;
    if (m_commit) begin
      if (!m_err(m_awaddr)) begin
        idx = int'(m_awaddr >> LSB);
        for (int b = 0; b < SW; b++)
          if (m_wstrb[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
      end
      m_bresp = m_err(m_awaddr) ? 2'b10 : 2'b00;
      m_bvalid = 1; m_aw_got = 0; m_w_got = 0; m_commit = 0;
    end else begin
      if (AWVALID && awr) begin m_aw_got = 1; m_awaddr = AWADDR; end
      if (WVALID && wr) begin m_w_got = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
      if (m_aw_got && m_w_got) m_commit = 1;
    end
    m_rdy_ok = 1;
  endfunction

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, 64'd0);
      model_reset();
      m_rdy_ok = !rst;
    end else begin
      e_awr = m_rdy_ok && !m_bvalid && !m_aw_got;
      e_wr  = m_rdy_ok && !m_bvalid && !m_w_got;
      e_arr = m_rdy_ok && !m_rvalid;
      chk("awready", AWREADY, e_awr);
      chk("wready", WREADY, e_wr);
      chk("arready", ARREADY, e_arr);
      chk("bvalid", BVALID, m_bvalid);
      if (m_bvalid) chk("bresp", BRESP, m_bresp);
      chk("rvalid", RVALID, m_rvalid);
      if (m_rvalid) begin
        chk("rresp", RRESP, m_rresp);
        chk("rdata", RDATA, m_rdata);
      end
      if (rst) model_reset();
      else model_step(e_awr, e_wr, e_arr);
    end
  end

  // ---------------- directed helpers (called at posedge + 1) ----------------
  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    AWADDR = a; AWVALID = 1'b1;
    @(negedge clk);
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    chk("aw_wait_timeout", n >= 50, 0);
    @(posedge clk); #1 AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    @(negedge clk);
    while (!WREADY && n < 50) begin @(negedge clk); n++; end
    chk("w_wait_timeout", n >= 50, 0);
    @(posedge clk); #1 WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    ARADDR = a; ARVALID = 1'b1;
    @(negedge clk);
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    chk("ar_wait_timeout", n >= 50, 0);
    @(posedge clk); #1 ARVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    chk("b_wait_timeout", n >= 50, 0);
    r = BRESP;
    @(posedge clk); #1;
  endtask

  task automatic wait_r(output logic [DW-1:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    while (!RVALID && n < 50) begin @(negedge clk); n++; end
    chk("r_wait_timeout", n >= 50, 0);
    d = RDATA; r = RRESP;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                    output logic [1:0] r);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(r);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
    send_ar(a);
    wait_r(d, r);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int k;
    k = int'($urandom_range(0, 11));
    case (k)
      0: return AW'(32'h400 + ($urandom_range(0, 15) << 2));
      1: return AW'(($urandom_range(0, 7) << 2) | $urandom_range(1, 3));
      2: return AW'(32'hFFFF_FFFC);
      3: return AW'(32'h3FC);
      default: return AW'($urandom_range(0, 7) << 2);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic [1:0]    r, rr;
    logic          hs_aw, hs_w, hs_ar;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_first_cycle", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge clk);
    chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge clk); #1;

    rd(32'h14, d, r);
    chk("rd_reset_data", d, 32'h0);
    chk("rd_reset_resp", r, 2'b00);

    // W two cycles ahead of AW
    send_w(32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    send_aw(32'h14);
    @(negedge clk);
    chk("b_latency_edge_n", BVALID, 1'b0);
    @(negedge clk);
    chk("b_latency_edge_n1", BVALID, 1'b1);
    chk("w_before_aw_resp", BRESP, 2'b00);
    @(posedge clk); #1;
    rd(32'h14, d, r);
    chk("w_before_aw_data", d, 32'hDEAD_BEEF);

    wr(32'h14, 32'h1122_3344, 4'b0101, r);
    chk("strobe_resp", r, 2'b00);
    rd(32'h14, d, r);
    chk("strobe_data", d, 32'hDE22_BE44);

    // out of range with B held off
    BREADY = 1'b0;
    fork
      send_aw(32'h400);
      send_w(32'hFFFF_FFFF, 4'hF);
    join
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("oor_bvalid_held", BVALID, 1'b1);
      chk("oor_bresp_held", BRESP, 2'b10);
      chk("oor_awready_low", AWREADY, 1'b0);
    end
    @(posedge clk); #1 BREADY = 1'b1;
    wait_b(r);
    chk("oor_bresp", r, 2'b10);
    rd(32'h400, d, r);
    chk("oor_rd_data", d, 32'h0);
    chk("oor_rd_resp", r, 2'b10);
    rd(32'h14, d, r);
    chk("oor_array_unchanged", d, 32'hDE22_BE44);
    rd(32'h0, d, r);
    chk("oor_idx0_unchanged", d, 32'h0);

    // write commit and read sample on the same edge
    wr(32'h20, 32'h1, 4'hF, r);
    fork
      send_aw(32'h20);
      send_w(32'h2, 4'hF);
    join
    send_ar(32'h20);
    fork
      wait_b(r);
      wait_r(d, rr);
    join
    chk("collision_old_value", d, 32'h1);
    rd(32'h20, d, r);
    chk("collision_new_value", d, 32'h2);

    wr(32'h15, 32'hAA, 4'hF, r);
    rd(32'h14, d, rr);
`ifdef AXIL_REGFILE_ALIGN_CHECK_EN
    chk("misaligned_bresp", r, 2'b10);
    chk("misaligned_no_write", d, 32'hDE22_BE44);
    rd(32'h15, d, r);
    chk("misaligned_rresp", r, 2'b10);
    chk("misaligned_rdata", d, 32'h0);
`else
    chk("misaligned_bresp", r, 2'b00);
    chk("misaligned_alias", d, 32'hAA);
`endif

    // randomised traffic, with a reset dropped into the middle of it
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_ar = ARVALID && ARREADY;
      @(posedge clk); #1;
      if (c >= 1200 && c < 1203) begin
        rst = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      end else begin
        rst = 1'b0;
        if (!AWVALID || hs_aw) begin
          AWVALID = ($urandom_range(0, 2) == 0);
          AWADDR  = rand_addr();
        end
        if (!WVALID || hs_w) begin
          WVALID = ($urandom_range(0, 2) == 0);
          WDATA  = $urandom;
          WSTRB  = SW'($urandom_range(0, 15));
        end
        if (!ARVALID || hs_ar) begin
          ARVALID = ($urandom_range(0, 2) == 0);
          ARADDR  = rand_addr();
        end
        BREADY = ($urandom_range(0, 3) != 0);
        RREADY = ($urandom_range(0, 3) != 0);
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
